// File: rtl/rv32_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// rv32_wb_arbiter_if
//   Bus bundle between the write-back producers / issue stage and the
//   write-back arbiter.
//
//   Handshake: requester i offers a result by raising req_valid[i] together
//   with stable req_rd[i]/req_data[i]; the arbiter answers with req_ready[i].
//   A transfer happens in every cycle where req_valid[i] & req_ready[i] is
//   high at the rising edge. The requester keeps valid/rd/data stable until
//   that transfer; ready may depend combinationally on valid.
//
//   Signal groups:
//     req_valid/req_ready/req_rd/req_data : write-back request handshake
//     rf_write/rf_rw/rf_d                 : register-file write port
//     issue_valid/issue_rd/issue_conflict : issue-stage destination check
//     query_rs/query_busy                 : pending-bit lookup for 3 sources
//
//   Modports:
//     slave  : arbiter side
//     master : producer / issue-stage side
// ---------------------------------------------------------------------------
interface rv32_wb_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0][4:0]  req_rd;
  logic [NUM_REQ-1:0][31:0] req_data;

  logic                     rf_write;
  logic [4:0]               rf_rw;
  logic [31:0]              rf_d;

  logic                     issue_valid;
  logic [4:0]               issue_rd;
  logic                     issue_conflict;

  logic [2:0][4:0]          query_rs;
  logic [2:0]               query_busy;

  modport slave (
    input  req_valid, req_rd, req_data, issue_valid, issue_rd, query_rs,
    output req_ready, rf_write, rf_rw, rf_d, issue_conflict, query_busy
  );

  modport master (
    output req_valid, req_rd, req_data, issue_valid, issue_rd, query_rs,
    input  req_ready, rf_write, rf_rw, rf_d, issue_conflict, query_busy
  );
endinterface

// File: rtl/rv32_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rv32_wb_arbiter
//   Write-back arbiter and register scoreboard in front of the single write
//   port of the register file. One requester is granted per cycle; the
//   granted result is registered and drives rf_write/rf_rw/rf_d during the
//   following cycle. A pending bit per architectural register lets the issue
//   stage detect RAW/WAW hazards.
//
//   Ports:
//     clk  : core clock, all state updates on the rising edge
//     rst  : synchronous, active-high reset
//     bus  : rv32_wb_arbiter_if.slave (request handshake, register-file
//            write port, issue check, source-register queries)
//
//   Parameter:
//     NUM_REQ : number of write-back requesters (2..8)
//
//   Build option:
//     RV32_WB_ARB_ROUND_ROBIN_EN defined   -> rotating priority, search starts
//                                             after the last granted index
//     RV32_WB_ARB_ROUND_ROBIN_EN undefined -> fixed priority, lowest index wins
// ---------------------------------------------------------------------------
module rv32_wb_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic              clk,
  input  logic              rst,
  rv32_wb_arbiter_if.slave  bus
);

  localparam int IW = $clog2(NUM_REQ);
  typedef logic [IW-1:0] idx_t;

  // -------------------------------------------------------------------------
  // Grant selection
  // -------------------------------------------------------------------------
  logic [NUM_REQ-1:0] grant;
  idx_t               gidx;
  logic               xfer;
  logic [4:0]         sel_rd;
  logic [31:0]        sel_data;

`ifdef RV32_WB_ARB_ROUND_ROBIN_EN
  // ptr_q holds the index of the last transfer; the search begins one past it.
  idx_t ptr_q;
  idx_t ptr_d;

  always_comb begin
    int best;
    int rank;
    grant = '0;
    gidx  = '0;
    best  = NUM_REQ;
    rank  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // rank 0 is index ptr+1, rank NUM_REQ-1 is ptr itself
      rank = (i + NUM_REQ - 1 - int'(ptr_q)) % NUM_REQ;
      if (bus.req_valid[i] && rank < best) begin
        best = rank;
        gidx = idx_t'(i);
      end
    end
    if (best < NUM_REQ && !rst) begin
      grant[gidx] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = gidx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= idx_t'(NUM_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    logic found;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    // Descending scan so the lowest valid index is the last one recorded.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        gidx  = idx_t'(i);
        found = 1'b1;
      end
    end
    if (found && !rst) begin
      grant[gidx] = 1'b1;
    end
  end
`endif

  assign bus.req_ready = grant;
  assign xfer          = |grant;
  assign sel_rd        = bus.req_rd[gidx];
  assign sel_data      = bus.req_data[gidx];

  // -------------------------------------------------------------------------
  // Output stage
  // -------------------------------------------------------------------------
  logic        rf_write_q, rf_write_d;
  logic [4:0]  rf_rw_q,    rf_rw_d;
  logic [31:0] rf_d_q,     rf_d_d;

  always_comb begin
    rf_write_d = 1'b0;
    rf_rw_d    = rf_rw_q;
    rf_d_d     = rf_d_q;
    if (xfer) begin
      // A result aimed at x0 still consumes its grant but never writes.
      rf_write_d = (sel_rd != 5'd0);
      rf_rw_d    = sel_rd;
      rf_d_d     = sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_write_q <= 1'b0;
      rf_rw_q    <= 5'd0;
      rf_d_q     <= 32'd0;
    end else begin
      rf_write_q <= rf_write_d;
      rf_rw_q    <= rf_rw_d;
      rf_d_q     <= rf_d_d;
    end
  end

  assign bus.rf_write = rf_write_q;
  assign bus.rf_rw    = rf_rw_q;
  assign bus.rf_d     = rf_d_q;

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  // Bit 0 is kept in the vector only so lookups need no x0 special case;
  // it is forced to 0 every cycle.
  logic [31:0] busy_q, busy_d;
  logic        issue_set;

  assign bus.issue_conflict = bus.issue_valid & busy_q[bus.issue_rd];
  assign issue_set = bus.issue_valid & ~bus.issue_conflict &
                     (bus.issue_rd != 5'd0);

  always_comb begin
    busy_d = busy_q;
    if (xfer) begin
      busy_d[sel_rd] = 1'b0;
    end
    // Applied after the clear so a same-register set/clear leaves it busy.
    if (issue_set) begin
      busy_d[bus.issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 32'd0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Lookups see current state only; a transfer in flight is not bypassed.
  always_comb begin
    bus.query_busy = '0;
    for (int k = 0; k < 3; k++) begin
      bus.query_busy[k] = busy_q[bus.query_rs[k]];
    end
  end

endmodule
